ball_engine: RTL
================

Name: ball_engine

Overview:
- Ball physics block that produces the `ballStatus` code the game-state FSM consumes, and takes that FSM's `state` back as its control input.
- Holds the ball at centre outside PLAY, moves it on a divided tick during PLAY, bounces it off walls and paddles, and reports a miss as a one-cycle PLAYER1WIN/PLAYER2WIN code.
- Outputs ball coordinates to the renderer.

Parameters:
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- BALL_SIZE, 8, ball edge length (square)
- PADDLE_W, 8, paddle width
- PADDLE_H, 64, paddle height
- P1_X, 16, left paddle x (left edge)
- P2_X, 616, right paddle x (left edge)
- SPEED_X, 2, horizontal pixels per step
- SPEED_Y, 1, vertical pixels per step
- TICK_DIV, 416667, clk cycles per movement step

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- state  in  2  game state: 00 START, 01 SERVE, 10 PLAY, 11 DONE
- paddle1_y  in  10  left paddle top y
- paddle2_y  in  10  right paddle top y
- ball_x  out  10  ball left x, registered
- ball_y  out  10  ball top y, registered
- ballStatus  out  2  00 PLAYING, 01 PLAYER1WIN, 10 PLAYER2WIN; 11 never driven

Behaviour:
- Reset (async, rst=1):
  - ball_x = (SCREEN_W-BALL_SIZE)/2 (316); ball_y = (SCREEN_H-BALL_SIZE)/2 (236).
  - ballStatus = 00; dx = +SPEED_X (right); dy = +SPEED_Y (down).
  - FSM = HOLD; tick counter = 0.
- FSM HOLD:
  - Ball forced to centre; tick counter held at 0.
  - On state==PLAY, go to MOVE.
- FSM MOVE:
  - Tick counter counts 0..TICK_DIV-1. One step executes on the cycle the counter equals TICK_DIV-1, so the first step occurs exactly TICK_DIV cycles after entering MOVE.
  - If state leaves PLAY while in MOVE, go to HOLD next cycle with no status pulse.
- FSM SCORED:
  - Ball frozen; ballStatus = 00.
  - On state!=PLAY, go to HOLD.
- Step, with nx = ball_x+dx and ny = ball_y+dy computed signed, 11 bits:
  - Top wall: if ny<=0, ball_y=0 and dy=+SPEED_Y.
  - Bottom wall: if ny>=SCREEN_H-BALL_SIZE, ball_y=SCREEN_H-BALL_SIZE and dy=-SPEED_Y.
  - Otherwise ball_y=ny.
- Vertical overlap test for paddle p, using current ball_y: (ball_y+BALL_SIZE > p_y) and (ball_y < p_y+PADDLE_H).
- Left paddle hit: dx<0, ball_x>=P1_X+PADDLE_W, nx<P1_X+PADDLE_W, and overlap with paddle1. Then ball_x=P1_X+PADDLE_W and dx=+SPEED_X.
- Right paddle hit: dx>0, ball_x+BALL_SIZE<=P2_X, nx+BALL_SIZE>P2_X, and overlap with paddle2. Then ball_x=P2_X-BALL_SIZE and dx=-SPEED_X.
- Left miss: dx<0 and nx<0.
  - ballStatus=10 (PLAYER2WIN) for exactly one cycle; go to SCORED.
  - ball_x unchanged on that step.
- Right miss: dx>0 and nx>SCREEN_W-BALL_SIZE.
  - ballStatus=01 (PLAYER1WIN) for exactly one cycle; go to SCORED.
- Otherwise ball_x=nx.
- Precedence and simultaneous events:
  - Paddle hit takes precedence over miss.
  - Wall bounce and paddle bounce in the same step both apply.
  - Wall handling still applies on a miss step.
- Serve direction:
  - dx sign is retained after a miss, so the next serve heads toward the side that conceded.
  - dy sign toggles on every HOLD->MOVE transition after the first.
- ballStatus is 00 in every cycle other than the single miss cycle.
- Reset mid-operation returns all outputs to reset values immediately.

Test Plan:
- Reset, then state=PLAY with TICK_DIV=4 -> ball_x=316 and ball_y=236 until cycle 4 after PLAY; then 318/237, then 320/238 four cycles later.
- PLAY with paddle2_y=200 and the ball driven right until its right edge would cross x=616 -> ball_x clamps to 608, dx becomes -2, ballStatus stays 00.
- PLAY with paddle1_y=0 and the ball heading left at y=236 -> after the step where nx<0, ballStatus=10 for exactly 1 cycle, then 00. Ball frozen until state=SERVE, then ball_x/ball_y=316/236.
- Ball travelling up reaching ny<=0 -> ball_y=0, dy becomes +1 on the same step. Bottom: ball_y clamps to 472.
- Right miss gives ballStatus=01 for one cycle. Hold state=PLAY for 20 further cycles -> no repeat pulse. Next serve starts moving right with dy inverted.
- Assert rst mid-MOVE at ball_x=400 -> outputs return to 316/236/00 asynchronously; no step occurs until a fresh PLAY entry plus TICK_DIV cycles.

Source files
------------

// File: rtl/ball_engine.sv
// Ball motion for the pong datapath: centres the ball outside PLAY, steps it on a
// divided tick, bounces off walls/paddles and reports a miss as a one-cycle status code.
module ball_engine #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_W  = 8,
  parameter int PADDLE_H  = 64,
  parameter int P1_X      = 16,
  parameter int P2_X      = 616,
  parameter int SPEED_X   = 2,
  parameter int SPEED_Y   = 1,
  parameter int TICK_DIV  = 416667
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic [9:0] paddle1_y,
  input  logic [9:0] paddle2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] ballStatus
);

  localparam logic [1:0] GAME_PLAY = 2'b10;

  localparam logic [1:0] HOLD   = 2'd0;
  localparam logic [1:0] MOVE   = 2'd1;
  localparam logic [1:0] SCORED = 2'd2;

  localparam logic [1:0] PLAYING    = 2'b00;
  localparam logic [1:0] PLAYER1WIN = 2'b01;
  localparam logic [1:0] PLAYER2WIN = 2'b10;

  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [9:0] X_CTR   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] Y_CTR   = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0] Y_BOT   = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0] X_P1_R  = 10'(P1_X + PADDLE_W);
  localparam logic [9:0] X_P2_CL = 10'(P2_X - BALL_SIZE);

  // 12-bit signed arithmetic keeps paddle_y+PADDLE_H and ball_x+dx free of wrap-around
  localparam logic signed [11:0] ZERO     = 12'sd0;
  localparam logic signed [11:0] SPD_X    = 12'(SPEED_X);
  localparam logic signed [11:0] SPD_Y    = 12'(SPEED_Y);
  localparam logic signed [11:0] X_MAX    = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] Y_MAX    = 12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0] P1_EDGE  = 12'(P1_X + PADDLE_W);
  localparam logic signed [11:0] P2_EDGE  = 12'(P2_X);
  localparam logic signed [11:0] BALL_S   = 12'(BALL_SIZE);
  localparam logic signed [11:0] PAD_H    = 12'(PADDLE_H);

  logic [1:0]       fsm_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             dx_neg;
  logic             dy_neg;
  logic             served;

  logic signed [11:0] bx_s, by_s, p1_s, p2_s, nx, ny;
  logic               ov1, ov2;
  logic [9:0]         x_step, y_step;
  logic               dx_step, dy_step;
  logic [1:0]         miss_code;

  assign bx_s = $signed({2'b00, ball_x});
  assign by_s = $signed({2'b00, ball_y});
  assign p1_s = $signed({2'b00, paddle1_y});
  assign p2_s = $signed({2'b00, paddle2_y});
  assign nx   = bx_s + (dx_neg ? -SPD_X : SPD_X);
  assign ny   = by_s + (dy_neg ? -SPD_Y : SPD_Y);

  // Overlap is judged on the pre-step ball_y
  assign ov1 = (by_s + BALL_S > p1_s) && (by_s < p1_s + PAD_H);
  assign ov2 = (by_s + BALL_S > p2_s) && (by_s < p2_s + PAD_H);

  always_comb begin
    x_step    = ball_x;
    y_step    = ball_y;
    dx_step   = dx_neg;
    dy_step   = dy_neg;
    miss_code = PLAYING;

    if (ny <= ZERO) begin
      y_step  = '0;
      dy_step = 1'b0;
    end else if (ny >= Y_MAX) begin
      y_step  = Y_BOT;
      dy_step = 1'b1;
    end else begin
      y_step = ny[9:0];
    end

    // Paddle hits are tested before misses so a paddle always wins
    if (dx_neg && (bx_s >= P1_EDGE) && (nx < P1_EDGE) && ov1) begin
      x_step  = X_P1_R;
      dx_step = 1'b0;
    end else if (!dx_neg && (bx_s + BALL_S <= P2_EDGE) && (nx + BALL_S > P2_EDGE) && ov2) begin
      x_step  = X_P2_CL;
      dx_step = 1'b1;
    end else if (dx_neg && (nx < ZERO)) begin
      miss_code = PLAYER2WIN;
    end else if (!dx_neg && (nx > X_MAX)) begin
      miss_code = PLAYER1WIN;
    end else begin
      x_step = nx[9:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg    <= HOLD;
      cnt_reg    <= '0;
      ball_x     <= X_CTR;
      ball_y     <= Y_CTR;
      ballStatus <= PLAYING;
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b0;
      served     <= 1'b0;
    end else begin
      ballStatus <= PLAYING;
      case (fsm_reg)
        HOLD: begin
          ball_x  <= X_CTR;
          ball_y  <= Y_CTR;
          cnt_reg <= '0;
          if (state == GAME_PLAY) begin
            fsm_reg <= MOVE;
            served  <= 1'b1;
            // Alternate vertical serve direction from the second serve on
            if (served) dy_neg <= ~dy_neg;
          end
        end
        MOVE: begin
          if (state != GAME_PLAY) begin
            fsm_reg <= HOLD;
            cnt_reg <= '0;
            ball_x  <= X_CTR;
            ball_y  <= Y_CTR;
          end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            ball_x  <= x_step;
            ball_y  <= y_step;
            dx_neg  <= dx_step;
            dy_neg  <= dy_step;
            if (miss_code != PLAYING) begin
              ballStatus <= miss_code;
              fsm_reg    <= SCORED;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        SCORED: begin
          if (state != GAME_PLAY) begin
            fsm_reg <= HOLD;
            ball_x  <= X_CTR;
            ball_y  <= Y_CTR;
          end
        end
        default: fsm_reg <= HOLD;
      endcase
    end
  end

endmodule
